// File: rtl/char_uart_tx.sv
// char_uart_tx: snapshots x/y/level and sends them as a framed 8N1 packet.
// Optional checksum byte appended when CHAR_UART_TX_CHECKSUM_EN is defined.
module char_uart_tx #(
    parameter int          CLKS_PER_BIT = 564,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send_req,
    input  logic [11:0] x_value,
    input  logic [11:0] y_value,
    input  logic [1:0]  level,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int CW = $clog2(CLKS_PER_BIT);

`ifdef CHAR_UART_TX_CHECKSUM_EN
    localparam logic [2:0] LAST = 3'd5;
`else
    localparam logic [2:0] LAST = 3'd4;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_n;
    logic [2:0]  byte_idx, byte_n;
    logic [7:0]  shift, shift_n;
    logic        pending, pend_n;
    logic        tx_n, busy_n, done_n;
    logic        load;
    logic        bit_end;
    logic [11:0] snap_x, snap_y;
    logic [1:0]  snap_lvl;
    logic [2:0]  nxt_idx;
    logic [7:0]  nxt_byte;

    assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));
    assign nxt_idx = byte_idx + 3'd1;

`ifdef CHAR_UART_TX_CHECKSUM_EN
    logic [7:0] csum;
    assign csum = snap_x[7:0] ^ {snap_y[3:0], snap_x[11:8]}
                ^ snap_y[11:4] ^ {6'b0, snap_lvl};
`endif

    // Select the packet byte that follows the one currently on the line
    always_comb begin
        nxt_byte = HEADER;
        case (nxt_idx)
            3'd1:    nxt_byte = snap_x[7:0];
            3'd2:    nxt_byte = {snap_y[3:0], snap_x[11:8]};
            3'd3:    nxt_byte = snap_y[11:4];
            3'd4:    nxt_byte = {6'b0, snap_lvl};
`ifdef CHAR_UART_TX_CHECKSUM_EN
            3'd5:    nxt_byte = csum;
`endif
            default: nxt_byte = HEADER;
        endcase
    end

    // Next-state, counters and registered-output values
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        byte_n  = byte_idx;
        shift_n = shift;
        pend_n  = pending;
        tx_n    = tx;
        busy_n  = busy;
        done_n  = 1'b0;
        load    = 1'b0;
        if (state != IDLE && send_req) begin
            pend_n = 1'b1;
        end
        unique case (state)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (send_req || pending) begin
                    load    = 1'b1;
                    pend_n  = 1'b0;
                    state_n = START;
                    cnt_n   = '0;
                    byte_n  = 3'd0;
                    shift_n = HEADER;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    bit_n   = 3'd0;
                    tx_n    = shift[0];
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n   = bit_idx + 3'd1;
                        shift_n = {1'b0, shift[7:1]};
                        tx_n    = shift[1];
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (byte_idx < LAST) begin
                        byte_n  = nxt_idx;
                        shift_n = nxt_byte;
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= 3'd0;
            byte_idx <= 3'd0;
            shift    <= 8'd0;
            pending  <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            snap_x   <= 12'd0;
            snap_y   <= 12'd0;
            snap_lvl <= 2'd0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            shift    <= shift_n;
            pending  <= pend_n;
            tx       <= tx_n;
            busy     <= busy_n;
            done     <= done_n;
            if (load) begin
                snap_x   <= x_value;
                snap_y   <= y_value;
                snap_lvl <= level;
            end
        end
    end

endmodule

// File: tb/tb_char_uart_tx.sv
// tb_char_uart_tx: random and directed packets decoded from a per-cycle
// trace of tx and compared with bytes built from x/y/level arithmetic.
module tb_char_uart_tx;

    localparam int CPB = 4;
`ifdef CHAR_UART_TX_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif
    localparam int P = NB * 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        send_req = 1'b0;
    logic [11:0] x_value = '0;
    logic [11:0] y_value = '0;
    logic [1:0]  level = '0;
    logic        tx, busy, done;

    char_uart_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
        .clk(clk), .rst(rst), .send_req(send_req),
        .x_value(x_value), .y_value(y_value), .level(level),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          cyc;
        logic        req;
        logic [11:0] x;
        logic [11:0] y;
        logic [1:0]  lv;
    } ev_t;

    ev_t  evq[$];
    logic tx_q[$];
    logic busy_q[$];
    logic done_q[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference packet byte k from the field values
    function automatic logic [7:0] ref_byte(input int x, input int y,
                                            input int lv, input int k);
        int b1, b2, b3, b4;
        b1 = x % 256;
        b2 = (y % 16) * 16 + x / 256;
        b3 = y / 16;
        b4 = lv;
        case (k)
            0: return 8'hA5;
            1: return 8'(b1);
            2: return 8'(b2);
            3: return 8'(b3);
            4: return 8'(b4);
            default: return 8'(b1 ^ b2 ^ b3 ^ b4);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        tx_q.push_back(tx);
        busy_q.push_back(busy);
        done_q.push_back(done);
    endtask

    task automatic run(input int n);
        tx_q.delete();
        busy_q.delete();
        done_q.delete();
        for (int c = 0; c < n; c++) begin
            send_req = 1'b0;
            foreach (evq[i]) begin
                if (evq[i].cyc == c) begin
                    send_req = evq[i].req;
                    x_value  = evq[i].x;
                    y_value  = evq[i].y;
                    level    = evq[i].lv;
                end
            end
            tick();
        end
        send_req = 1'b0;
    endtask

    function automatic int count_q(input logic q[$]);
        int s = 0;
        foreach (q[i]) s += int'(q[i]);
        return s;
    endfunction

    function automatic int first_done();
        foreach (done_q[i]) if (done_q[i]) return i;
        return -1;
    endfunction

    // Decode one 10-slot frame; every slot must hold for exactly CPB cycles
    task automatic decode(input int base, output logic [7:0] val,
                          output logic ok);
        logic v;
        val = 8'h00;
        ok  = 1'b1;
        for (int s = 0; s < 10; s++) begin
            int pos = base + s * CPB;
            if (pos + CPB - 1 >= tx_q.size()) begin
                ok = 1'b0;
            end else begin
                v = tx_q[pos];
                for (int j = 1; j < CPB; j++)
                    if (tx_q[pos + j] !== v) ok = 1'b0;
                if (s == 0 && v !== 1'b0) ok = 1'b0;
                if (s == 9 && v !== 1'b1) ok = 1'b0;
                if (s >= 1 && s <= 8) val[s - 1] = v;
            end
        end
    endtask

    task automatic check_packet(input string tag, input int base,
                                input int x, input int y, input int lv);
        logic [7:0] b;
        logic ok;
        for (int k = 0; k < NB; k++) begin
            decode(base + k * 10 * CPB, b, ok);
            check($sformatf("%s_b%0d", tag, k), {24'd0, b},
                  {24'd0, ref_byte(x, y, lv, k)});
            check($sformatf("%s_tim%0d", tag, k), {31'd0, ok}, 32'd1);
        end
        if (base + P < busy_q.size()) begin
            check({tag, "_busy_end"}, {30'd0, busy_q[base + P - 1],
                  busy_q[base + P]}, 32'd2);
            check({tag, "_done"}, {31'd0, done_q[base + P]}, 32'd1);
        end else begin
            check({tag, "_trace_short"}, 32'd0, 32'd1);
        end
    endtask

    task automatic single(input string tag, input int x, input int y,
                          input int lv);
        evq.delete();
        evq.push_back('{0, 1'b1, 12'(x), 12'(y), 2'(lv)});
        run(P + 5);
        check({tag, "_start"}, {30'd0, tx_q[0], busy_q[0]}, 32'd1);
        check({tag, "_busy_cnt"}, count_q(busy_q), P);
        check({tag, "_done_cnt"}, count_q(done_q), 1);
        check_packet(tag, 0, x, y, lv);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        check("rst_state", {29'd0, tx, busy, done}, 32'b100);
        rst = 1'b0;
        tick();
        check("idle_state", {29'd0, tx, busy, done}, 32'b100);

        evq.delete();
        evq.push_back('{0, 1'b1, 12'h123, 12'h2AB, 2'd2});
        evq.push_back('{10, 1'b0, 12'hFFF, 12'h2AB, 2'd2});
        run(P + 5);
        check("sp_start", {30'd0, tx_q[0], busy_q[0]}, 32'd1);
        check("sp_busy_cnt", count_q(busy_q), P);
        check("sp_done_cnt", count_q(done_q), 1);
        check("sp_done_pos", first_done(), P);
        check_packet("sp", 0, 'h123, 'h2AB, 2);

        evq.delete();
        evq.push_back('{0, 1'b1, 12'h123, 12'h2AB, 2'd2});
        evq.push_back('{50, 1'b1, 12'h045, 12'h2AB, 2'd2});
        run(2 * P + 5);
        check_packet("pend1", 0, 'h123, 'h2AB, 2);
        check("pend_gap", {30'd0, tx_q[P], busy_q[P]}, 32'b10);
        check("pend_restart", {30'd0, tx_q[P + 1], busy_q[P + 1]}, 32'b01);
        check_packet("pend2", P + 1, 'h045, 'h2AB, 2);
        check("pend_busy_cnt", count_q(busy_q), 2 * P);
        check("pend_done_cnt", count_q(done_q), 2);

        evq.delete();
        evq.push_back('{0, 1'b1, 12'h321, 12'h0F0, 2'd1});
        evq.push_back('{20, 1'b1, 12'h321, 12'h0F0, 2'd1});
        evq.push_back('{60, 1'b1, 12'h321, 12'h0F0, 2'd1});
        evq.push_back('{100, 1'b1, 12'h321, 12'h0F0, 2'd1});
        run(3 * P + 5);
        check("merge_done_cnt", count_q(done_q), 2);
        check("merge_busy_cnt", count_q(busy_q), 2 * P);

        single("max", 'hFFF, 'hFFF, 3);
        single("zero", 0, 0, 0);

        for (int i = 0; i < 4; i++) begin
            int rx, ry, rl;
            rx = int'($urandom_range(0, 4095));
            ry = int'($urandom_range(0, 4095));
            rl = int'($urandom_range(0, 3));
            single($sformatf("rnd%0d", i), rx, ry, rl);
        end

        evq.delete();
        evq.push_back('{0, 1'b1, 12'h5A5, 12'h3C3, 2'd1});
        run(15);
        rst = 1'b1;
        tick();
        check("midrst_state", {29'd0, tx, busy, done}, 32'b100);
        rst = 1'b0;
        evq.delete();
        run(P + 5);
        check("midrst_no_busy", count_q(busy_q), 0);
        check("midrst_no_done", count_q(done_q), 0);
        check("midrst_tx_idle", count_q(tx_q), P + 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
